// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the MEM-stage load/store unit, the instruction
// decoder and the data memory: FSM state type, funct3 field constants and
// the size / byte-lane decode helpers.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } lsu_state_t;

    // funct3[1:0] selects the access size, funct3[2] marks an unsigned load.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam int         F3_UNSIGNED_BIT = 2;
    localparam logic [2:0] F3_LOAD_ILLEGAL = 3'b111;

    // Access size in bytes (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] size_code);
        return 4'd1 << size_code;
    endfunction

    // Byte lanes touched by an access, spanning two doublewords:
    // bits [7:0] belong to the first beat, bits [15:8] to the second.
    function automatic logic [15:0] lane_mask(input logic [1:0] size_code,
                                              input logic [2:0] off);
        logic [15:0] m;
        m = 16'h0000;
        case (size_code)
            SIZE_B:  m = 16'h0001;
            SIZE_H:  m = 16'h0003;
            SIZE_W:  m = 16'h000F;
            SIZE_D:  m = 16'h00FF;
            default: m = 16'h0000;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the pipeline request/response handshake and the data-memory
// doubleword port of the load/store unit.
//   slave  : the LSU (takes requests, returns responses, drives memory beats)
//   master : its environment (pipeline side plus data memory read data)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  access request
//   resp_valid/resp_rdata/resp_fault                          1-cycle response
//   mem_req/mem_addr/mem_we/mem_wstrb/mem_wdata               memory beat
//   mem_rdata                                                 combinational read
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [7:0]      mem_wstrb;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/load_store_unit_load_align_ext.sv
// -----------------------------------------------------------------------------
// load_align_ext
// Combinational load data path: takes the two doublewords a load may span,
// shifts the addressed bytes down to bit 0, keeps the access size and
// sign- or zero-extends to 64 bits.
// Ports:
//   lo     in  64  first doubleword (beat0 / only beat)
//   hi     in  64  second doubleword (beat1, zero when not split)
//   off    in  3   byte offset of the access inside lo
//   funct3 in  3   load funct3 (size in [1:0], unsigned in [2])
//   data   out 64  extended load result
// -----------------------------------------------------------------------------
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [63:0] lo,
    input  logic [63:0] hi,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] window;
    logic        zext;

    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // branching, so no path can leave it unassigned and infer a latch.
        window = 64'({hi, lo} >> {off, 3'b000});
        zext   = funct3[F3_UNSIGNED_BIT];
        data   = window;
        case (funct3[1:0])
            SIZE_B:  data = zext ? {56'b0, window[7:0]}  : {{56{window[7]}},  window[7:0]};
            SIZE_H:  data = zext ? {48'b0, window[15:0]} : {{48{window[15]}}, window[15:0]};
            SIZE_W:  data = zext ? {32'b0, window[31:0]} : {{32{window[31]}}, window[31:0]};
            default: data = window;   // doubleword: nothing to extend
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// MEM-stage load/store unit of the RV64 core. Accepts one access per
// handshake, drives the 8-byte aligned data memory port with byte strobes,
// splits accesses crossing a doubleword boundary into two beats and returns
// merged, extended load data. Illegal or out-of-range accesses fault without
// touching memory.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of load_store_unit_if (request, response, memory beat)
// Timing: unsplit access responds 1 cycle after accept, split access 2 cycles.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    load_store_unit_if.slave      bus
);

    // Compared at XLEN+1 bits so a carry out of base+8 counts as out of range.
    localparam logic [XLEN:0] MEM_LIMIT = {{XLEN{1'b0}}, 1'b1} << MEM_ADDR_BITS;
    localparam logic [XLEN:0] DWORD     = {{(XLEN-3){1'b0}}, 4'd8};

    lsu_state_t state, state_next;

    // Request decode (valid in IDLE)
    logic [2:0]      offset;
    logic [XLEN-1:0] base;
    logic [XLEN:0]   base_hi;
    logic [1:0]      size_code;
    logic            split;
    logic [15:0]     mask16;
    logic            illegal;
    logic            out_of_range;
    logic            fault;

    // Fields held across the two beats of a split access
    logic            cap_we;
    logic [2:0]      cap_funct3;
    logic [2:0]      cap_off;
    logic [XLEN-1:0] cap_addr_hi;
    logic [XLEN-1:0] cap_wdata;
    logic [7:0]      cap_strb_hi;
    logic [XLEN-1:0] cap_rdata_lo;
    logic            cap_en;

    // Completion of the current access
    logic            done;
    logic            done_fault;
    logic            access_we;
    logic [XLEN-1:0] done_rdata;

    // Load alignment inputs, muxed by state
    logic [XLEN-1:0] align_lo;
    logic [XLEN-1:0] align_hi;
    logic [2:0]      align_off;
    logic [2:0]      align_funct3;
    logic [XLEN-1:0] align_data;

    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            resp_fault_q;

    always_comb begin
        offset       = bus.req_addr[2:0];
        base         = {bus.req_addr[XLEN-1:3], 3'b000};
        base_hi      = {1'b0, base} + DWORD;
        size_code    = bus.req_funct3[1:0];
        split        = ({1'b0, offset} + size_bytes(size_code)) > 4'd8;
        mask16       = lane_mask(size_code, offset);
        illegal      = bus.req_we ? bus.req_funct3[F3_UNSIGNED_BIT]
                                  : (bus.req_funct3 == F3_LOAD_ILLEGAL);
        out_of_range = ({1'b0, base} >= MEM_LIMIT) || (split && (base_hi >= MEM_LIMIT));
        fault        = illegal || out_of_range;
    end

    // FSM next state, memory beat and completion
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wstrb = 8'h00;
        bus.mem_wdata = '0;
        cap_en        = 1'b0;
        done          = 1'b0;
        done_fault    = 1'b0;
        access_we     = bus.req_we;
        align_lo      = bus.mem_rdata;
        align_hi      = '0;
        align_off     = offset;
        align_funct3  = bus.req_funct3;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (fault) begin
                        done       = 1'b1;
                        done_fault = 1'b1;
                    end else begin
                        bus.mem_req   = 1'b1;
                        bus.mem_addr  = base;
                        bus.mem_we    = bus.req_we;
                        bus.mem_wstrb = mask16[7:0];
                        bus.mem_wdata = bus.req_wdata << {offset, 3'b000};
                        if (split) begin
                            cap_en     = 1'b1;
                            state_next = SECOND;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
            end
            SECOND: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = cap_addr_hi;
                bus.mem_we    = cap_we;
                bus.mem_wstrb = cap_strb_hi;
                // off >= 1 whenever an access splits, so the shift is < 64.
                bus.mem_wdata = cap_wdata >> (7'd64 - {1'b0, cap_off, 3'b000});
                access_we     = cap_we;
                align_lo      = cap_rdata_lo;
                align_hi      = bus.mem_rdata;
                align_off     = cap_off;
                align_funct3  = cap_funct3;
                done          = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase

        done_rdata = (done_fault || access_we) ? '0 : align_data;
    end

    load_align_ext u_align (
        .lo     (align_lo),
        .hi     (align_hi),
        .off    (align_off),
        .funct3 (align_funct3),
        .data   (align_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its inputs from before the edge, independent of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the capture registers are reset as well; they are few, and it keeps
    // the beat1 drive values defined even though they are only used in SECOND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_we       <= 1'b0;
            cap_funct3   <= 3'b000;
            cap_off      <= 3'b000;
            cap_addr_hi  <= '0;
            cap_wdata    <= '0;
            cap_strb_hi  <= 8'h00;
            cap_rdata_lo <= '0;
        end else if (cap_en) begin
            cap_we       <= bus.req_we;
            cap_funct3   <= bus.req_funct3;
            cap_off      <= offset;
            cap_addr_hi  <= base_hi[XLEN-1:0];
            cap_wdata    <= bus.req_wdata;
            cap_strb_hi  <= mask16[15:8];
            cap_rdata_lo <= bus.mem_rdata;
        end
    end

    // Response: valid pulses for one cycle, data and fault hold until the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            resp_valid_q <= done;
            if (done) begin
                resp_rdata_q <= done_rdata;
                resp_fault_q <= done_fault;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: directed vector table, back-to-back
// and reset-during-split sequences, then random accesses against a byte-level
// memory model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    logic mem_clear;

    load_store_unit_if #(.XLEN(64)) bus ();

    load_store_unit #(
        .XLEN          (64),
        .MEM_ADDR_BITS (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- data memory device (1 KiB, byte array) ----------------
    logic [7:0] mem [0:1023];

    always_comb begin
        for (int i = 0; i < 8; i++)
            bus.mem_rdata[8*i +: 8] = mem[{bus.mem_addr[9:3], 3'(i)}];
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (bus.mem_req && bus.mem_we) begin
            for (int i = 0; i < 8; i++)
                if (bus.mem_wstrb[i]) mem[{bus.mem_addr[9:3], 3'(i)}] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // ---------------- beat monitor ----------------
    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  strb;
    } beat_t;
    beat_t beats [$];

    always @(negedge clk) begin
        if (bus.mem_req) beats.push_back('{addr: bus.mem_addr, strb: bus.mem_wstrb});
    end

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    logic [7:0] ref_mem [0:1023];

    function automatic int unsigned sz_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic is_split(input logic [2:0] f3, input logic [63:0] addr);
        return (int'(addr[2:0]) + sz_of(f3)) > 8;
    endfunction

    function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [63:0] addr);
        logic [63:0] base;
        logic [63:0] last;
        base = addr & ~64'h7;
        last = is_split(f3, addr) ? base + 64'd8 : base;
        if (we ? f3[2] : (f3 == 3'b111)) return 1'b1;
        return (base >= 64'd1024) || (last >= 64'd1024);
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr);
        logic [63:0] v;
        int          sz;
        v  = 64'd0;
        sz = sz_of(f3);
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[int'(addr[9:0]) + i];
        if (!f3[2] && sz < 8 && v[8*sz-1])
            for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
        for (int i = 0; i < int'(sz_of(f3)); i++) ref_mem[int'(addr[9:0]) + i] = wd[8*i +: 8];
    endtask

    task automatic model_strobes(input logic [2:0] f3, input logic [63:0] addr,
                                 output logic [7:0] s0, output logic [7:0] s1);
        int p;
        s0 = 8'h00;
        s1 = 8'h00;
        for (int i = 0; i < int'(sz_of(f3)); i++) begin
            p = int'(addr[2:0]) + i;
            if (p < 8) s0[p] = 1'b1;
            else       s1[p-8] = 1'b1;
        end
    endtask

    // ---------------- access driver ----------------
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wd, output logic [63:0] rdata,
                              output logic fault, output int lat);
        int n;
        beats.delete();
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        n = 0;
        while (!bus.req_ready && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("resp_seen", 64'(bus.resp_valid), 64'd1);
        rdata = bus.resp_rdata;
        fault = bus.resp_fault;
    endtask

    task automatic check_beats(input string tag, input int exp_n, input logic [63:0] addr,
                               input logic [7:0] s0, input logic [7:0] s1);
        logic [63:0] base;
        base = addr & ~64'h7;
        check({tag, "_beats"}, 64'(beats.size()), 64'(exp_n));
        check({tag, "_strb0"}, 64'(beats.size() > 0 ? beats[0].strb : 8'h00), 64'(exp_n > 0 ? s0 : 8'h00));
        check({tag, "_strb1"}, 64'(beats.size() > 1 ? beats[1].strb : 8'h00), 64'(exp_n > 1 ? s1 : 8'h00));
        check({tag, "_addr0"}, beats.size() > 0 ? beats[0].addr : 64'd0, exp_n > 0 ? base : 64'd0);
        check({tag, "_addr1"}, beats.size() > 1 ? beats[1].addr : 64'd0, exp_n > 1 ? base + 64'd8 : 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_beats;
        logic [7:0]  exp_s0;
        logic [7:0]  exp_s1;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wd, input logic [63:0] er, input logic ef,
                                input int el, input int eb, input logic [7:0] s0, input logic [7:0] s1);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.exp_rdata = er;
        v.exp_fault = ef; v.exp_lat = el; v.exp_beats = eb; v.exp_s0 = s0; v.exp_s1 = s1;
        return v;
    endfunction

    logic [63:0] got_rdata;
    logic        got_fault;
    int          got_lat;

    initial begin
        logic [63:0] b2b_addr [3];
        logic [63:0] b2b_exp  [3];
        logic        resp_seen;
        logic [63:0] wd;
        logic [63:0] addr;
        logic [2:0]  f3;
        logic        we;
        logic        e_fault;
        logic [63:0] e_rdata;
        logic [7:0]  s0;
        logic [7:0]  s1;
        int          bad;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        rst_n          = 1'b0;
        mem_clear      = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
        mem_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //          we  f3  addr                   wdata                  exp_rdata              flt lat bt s0     s1
        vecs.push_back(mk(1, 3, 64'h100, 64'h1122334455667788, 64'h0,                  0, 1, 1, 8'hFF, 8'h00)); // SD
        vecs.push_back(mk(0, 3, 64'h100, 64'h0,                64'h1122334455667788,   0, 1, 1, 8'hFF, 8'h00)); // LD
        vecs.push_back(mk(1, 2, 64'h106, 64'h00000000AABBCCDD, 64'h0,                  0, 2, 2, 8'hC0, 8'h03)); // SW split
        vecs.push_back(mk(0, 6, 64'h106, 64'h0,                64'h00000000AABBCCDD,   0, 2, 2, 8'hC0, 8'h03)); // LWU split
        vecs.push_back(mk(1, 0, 64'h203, 64'h1234567890ABCD80, 64'h0,                  0, 1, 1, 8'h08, 8'h00)); // SB
        vecs.push_back(mk(0, 0, 64'h203, 64'h0,                64'hFFFFFFFFFFFFFF80,   0, 1, 1, 8'h08, 8'h00)); // LB
        vecs.push_back(mk(0, 4, 64'h203, 64'h0,                64'h0000000000000080,   0, 1, 1, 8'h08, 8'h00)); // LBU
        vecs.push_back(mk(0, 3, 64'h3FC, 64'h0,                64'h0,                  1, 1, 0, 8'h00, 8'h00)); // LD beat1 OOR
        vecs.push_back(mk(1, 3, 64'h400, 64'hFFFFFFFFFFFFFFFF, 64'h0,                  1, 1, 0, 8'h00, 8'h00)); // SD OOR
        vecs.push_back(mk(0, 7, 64'h100, 64'h0,                64'h0,                  1, 1, 0, 8'h00, 8'h00)); // illegal load
        vecs.push_back(mk(1, 5, 64'h100, 64'hDEADBEEFDEADBEEF, 64'h0,                  1, 1, 0, 8'h00, 8'h00)); // illegal store
        vecs.push_back(mk(0, 1, 64'h107, 64'h0,                64'hFFFFFFFFFFFFBBCC,   0, 2, 2, 8'h80, 8'h01)); // LH split
        vecs.push_back(mk(0, 5, 64'h107, 64'h0,                64'h000000000000BBCC,   0, 2, 2, 8'h80, 8'h01)); // LHU split
        vecs.push_back(mk(0, 2, 64'h104, 64'h0,                64'hFFFFFFFFCCDD3344,   0, 1, 1, 8'hF0, 8'h00)); // LW
        vecs.push_back(mk(1, 3, 64'h3F8, 64'h0123456789ABCDEF, 64'h0,                  0, 1, 1, 8'hFF, 8'h00)); // SD last dword
        vecs.push_back(mk(0, 3, 64'h3F8, 64'h0,                64'h0123456789ABCDEF,   0, 1, 1, 8'hFF, 8'h00)); // LD last dword
        vecs.push_back(mk(0, 2, 64'h3FE, 64'h0,                64'h0,                  1, 1, 0, 8'h00, 8'h00)); // LW split OOR
        vecs.push_back(mk(0, 0, 64'h3FF, 64'h0,                64'h0000000000000001,   0, 1, 1, 8'h80, 8'h00)); // LB last byte
        vecs.push_back(mk(0, 3, 64'h109, 64'h0,                64'h00000000000000AA,   0, 2, 2, 8'hFE, 8'h01)); // LD split
        vecs.push_back(mk(1, 1, 64'h0FF, 64'h000000000000BEEF, 64'h0,                  0, 2, 2, 8'h80, 8'h01)); // SH split
        vecs.push_back(mk(0, 3, 64'h100, 64'h0,                64'hCCDD3344556677BE,   0, 1, 1, 8'hFF, 8'h00)); // LD merged
        vecs.push_back(mk(0, 2, 64'hFFFFFFFFFFFFFFFE, 64'h0,   64'h0,                  1, 1, 0, 8'h00, 8'h00)); // wrap

        foreach (vecs[k]) begin
            run_access(vecs[k].we, vecs[k].f3, vecs[k].addr, vecs[k].wdata, got_rdata, got_fault, got_lat);
            check($sformatf("vec%0d_rdata", k), got_rdata, vecs[k].exp_rdata);
            check($sformatf("vec%0d_fault", k), 64'(got_fault), 64'(vecs[k].exp_fault));
            check($sformatf("vec%0d_lat", k), 64'(got_lat), 64'(vecs[k].exp_lat));
            check_beats($sformatf("vec%0d", k), vecs[k].exp_beats, vecs[k].addr, vecs[k].exp_s0, vecs[k].exp_s1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse", k), 64'(bus.resp_valid), 64'd0);
            if (vecs[k].we && !vecs[k].exp_fault) model_store(vecs[k].f3, vecs[k].addr, vecs[k].wdata);
        end

        // ---- three aligned LW back-to-back, req_valid held high ----
        b2b_addr[0] = 64'h100;
        b2b_addr[1] = 64'h104;
        b2b_addr[2] = 64'h3F8;
        for (int k = 0; k < 3; k++) b2b_exp[k] = model_load(3'b010, b2b_addr[k]);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        for (int k = 0; k < 3; k++) begin
            bus.req_addr = b2b_addr[k];
            #1;
            check($sformatf("b2b%0d_ready", k), 64'(bus.req_ready), 64'd1);
            @(posedge clk); #1;
            check($sformatf("b2b%0d_valid", k), 64'(bus.resp_valid), 64'd1);
            check($sformatf("b2b%0d_rdata", k), bus.resp_rdata, b2b_exp[k]);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_pulse", 64'(bus.resp_valid), 64'd0);
        check("b2b_hold_rdata", bus.resp_rdata, b2b_exp[2]);

        // ---- reset asserted while a split SD is in its second beat ----
        wd = 64'hA1A2A3A4A5A6A7A8;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b011;
        bus.req_addr   = 64'h2FD;
        bus.req_wdata  = wd;
        #1;
        check("rsplit_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rsplit_busy", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rsplit_ready_async", 64'(bus.req_ready), 64'd1);
        check("rsplit_no_beat", 64'(bus.mem_req), 64'd0);
        resp_seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            resp_seen = resp_seen | bus.resp_valid;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            resp_seen = resp_seen | bus.resp_valid;
        end
        check("rsplit_no_resp", 64'(resp_seen), 64'd0);
        check("rsplit_ready_after", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 3; i++) ref_mem[16'h2FD + i] = wd[8*i +: 8];
        check("rsplit_beat0_kept", {40'd0, mem[10'h2FF], mem[10'h2FE], mem[10'h2FD]}, 64'h0000000000A6A7A8);
        check("rsplit_beat1_clean", {24'd0, mem[10'h304], mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]}, 64'd0);

        // ---- random accesses against the model ----
        for (int k = 0; k < 400; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       addr = {$urandom, $urandom};
                1:       addr = 64'h3F0 + 64'($urandom_range(0, 31));
                default: addr = 64'($urandom_range(0, 1023));
            endcase
            wd      = {$urandom, $urandom};
            e_fault = model_fault(we, f3, addr);
            e_rdata = (we || e_fault) ? 64'd0 : model_load(f3, addr);
            model_strobes(f3, addr, s0, s1);
            run_access(we, f3, addr, wd, got_rdata, got_fault, got_lat);
            check("rand_rdata", got_rdata, e_rdata);
            check("rand_fault", 64'(got_fault), 64'(e_fault));
            check("rand_lat", 64'(got_lat), (!e_fault && is_split(f3, addr)) ? 64'd2 : 64'd1);
            check_beats("rand", e_fault ? 0 : (is_split(f3, addr) ? 2 : 1), addr, s0, s1);
            if (we && !e_fault) model_store(f3, addr, wd);
        end

        // ---- whole memory against the model ----
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_final_bad_bytes", 64'(bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
